// File: rtl/crc32_pkg.sv
// rtl/crc32_pkg.sv - CRC-32 constants, FSM state type and byte-step function
package crc32_pkg;

  localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

  typedef enum logic {
    ACCUM  = 1'b0,
    RESULT = 1'b1
  } crc_state_t;

  // Reflected CRC-32: fold the byte into the low bits, then shift LSB-first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h000000, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc32_byte_step.sv
// rtl/crc32_byte_step.sv - combinational one-byte CRC-32 update
module crc32_byte_step
  import crc32_pkg::*;
(
  input  logic [31:0] state,
  input  logic [7:0]  data,
  output logic [31:0] next_state
);

  always_comb begin
    next_state = crc32_byte(state, data);
  end

endmodule

// File: rtl/crc32_frame_checker.sv
// rtl/crc32_frame_checker.sv - byte-stream CRC-32 FCS checker with held result handshake
module crc32_frame_checker
  import crc32_pkg::*;
#(
  parameter int LEN_W   = 16,
  parameter int MIN_LEN = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_ok,
  output logic [31:0]      res_crc,
  output logic [LEN_W-1:0] res_len
);

  localparam logic [LEN_W-1:0] LEN_MAX = '1;
  localparam logic [LEN_W-1:0] LEN_MIN = LEN_W'(MIN_LEN);

  crc_state_t       state;
  logic [31:0]      crc_reg;
  logic [31:0]      crc_next;
  logic [LEN_W-1:0] len_reg;
  logic [LEN_W-1:0] len_next;
  logic             xfer;

  crc32_byte_step u_step (
    .state      (crc_reg),
    .data       (in_data),
    .next_state (crc_next)
  );

  assign xfer     = in_valid && in_ready;
  assign len_next = (len_reg == LEN_MAX) ? len_reg : len_reg + LEN_W'(1);

  // in_ready and res_valid are registered copies of the state decode, so
  // neither output sees res_ready or reset combinationally.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ACCUM;
      crc_reg   <= CRC32_INIT;
      len_reg   <= '0;
      in_ready  <= 1'b0;
      res_valid <= 1'b0;
      res_ok    <= 1'b0;
      res_crc   <= 32'h0;
      res_len   <= '0;
    end else begin
      case (state)
        ACCUM: begin
          in_ready  <= 1'b1;
          res_valid <= 1'b0;
          if (xfer) begin
            crc_reg <= crc_next;
            len_reg <= len_next;
            if (in_last) begin
              state     <= RESULT;
              in_ready  <= 1'b0;
              res_valid <= 1'b1;
              res_crc   <= ~crc_next;
              res_len   <= len_next;
              res_ok    <= (crc_next == CRC32_RESIDUE) && (len_next >= LEN_MIN);
            end
          end
        end
        RESULT: begin
          if (res_ready) begin
            state     <= ACCUM;
            crc_reg   <= CRC32_INIT;
            len_reg   <= '0;
            in_ready  <= 1'b1;
            res_valid <= 1'b0;
          end
        end
        default: begin
          state    <= ACCUM;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_crc32_frame_checker.sv
// tb/tb_crc32_frame_checker.sv - directed self-checking bench for crc32_frame_checker
module tb_crc32_frame_checker;

  localparam int LEN_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_data;
  logic             in_last;
  logic             res_valid;
  logic             res_ready;
  logic             res_ok;
  logic [31:0]      res_crc;
  logic [LEN_W-1:0] res_len;

  int checks = 0;
  int errors = 0;

  logic [7:0] frame [0:31];
  int         flen;

  crc32_frame_checker #(.LEN_W(LEN_W), .MIN_LEN(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_ok    (res_ok),
    .res_crc   (res_crc),
    .res_len   (res_len)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load_030();
    for (int i = 0; i < 9; i++) frame[i] = 8'h31 + 8'(i);
    flen = 9;
  endtask

  task automatic load_031();
    load_030();
    frame[9]  = 8'h26;
    frame[10] = 8'h39;
    frame[11] = 8'hF4;
    frame[12] = 8'hCB;
    flen = 13;
  endtask

  task automatic wait_ready();
    int t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("in_ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_bytes(input int n, input bit gaps, input bit with_last);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        int g = $urandom_range(0, 3);
        for (int k = 0; k < g; k++) begin
          in_valid = 1'b0;
          in_data  = 8'($urandom);
          in_last  = 1'b1;
          @(negedge clk);
          check("idle_no_result", {31'd0, res_valid}, 32'd0);
        end
      end
      in_valid = 1'b1;
      in_data  = frame[i];
      in_last  = with_last && (i == n - 1);
      wait_ready();
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic take_result(input string tag, input logic [31:0] crc,
                             input logic [31:0] len, input logic ok);
    check({tag, "_valid"}, {31'd0, res_valid}, 32'd1);
    check({tag, "_crc"}, res_crc, crc);
    check({tag, "_len"}, {28'd0, res_len}, len);
    check({tag, "_ok"}, {31'd0, res_ok}, {31'd0, ok});
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check({tag, "_released"}, {31'd0, res_valid}, 32'd0);
    check({tag, "_ready_back"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_last   = 1'b0;
    res_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_res_valid", {31'd0, res_valid}, 32'd0);
    check("rst_res_ok", {31'd0, res_ok}, 32'd0);
    check("rst_res_crc", res_crc, 32'd0);
    check("rst_res_len", {28'd0, res_len}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    load_030();
    send_bytes(flen, 1'b0, 1'b1);
    take_result("check_str", 32'hCBF43926, 32'd9, 1'b0);

    load_031();
    send_bytes(flen, 1'b0, 1'b1);
    take_result("good_fcs", 32'h2144DF1C, 32'd13, 1'b1);

    frame[0] = 8'h61;
    flen = 1;
    send_bytes(flen, 1'b0, 1'b1);
    take_result("runt", 32'hE8B7BE43, 32'd1, 1'b0);

    load_031();
    send_bytes(flen, 1'b0, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
      check("hold_valid", {31'd0, res_valid}, 32'd1);
      check("hold_crc", res_crc, 32'h2144DF1C);
      check("hold_len", {28'd0, res_len}, 32'd13);
      check("hold_ok", {31'd0, res_ok}, 32'd1);
    end
    res_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h31;
    in_last   = 1'b0;
    @(negedge clk);
    res_ready = 1'b0;
    check("b2b_ready", {31'd0, in_ready}, 32'd1);
    check("b2b_released", {31'd0, res_valid}, 32'd0);
    load_030();
    send_bytes(flen, 1'b0, 1'b1);
    take_result("b2b_frame", 32'hCBF43926, 32'd9, 1'b0);

    load_030();
    send_bytes(6, 1'b0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check("abort_in_ready", {31'd0, in_ready}, 32'd0);
    check("abort_valid", {31'd0, res_valid}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("abort_rearm", {31'd0, in_ready}, 32'd1);
    check("abort_no_result", {31'd0, res_valid}, 32'd0);
    send_bytes(flen, 1'b0, 1'b1);
    take_result("after_abort", 32'hCBF43926, 32'd9, 1'b0);

    load_031();
    send_bytes(flen, 1'b1, 1'b1);
    take_result("gaps", 32'h2144DF1C, 32'd13, 1'b1);

    for (int i = 0; i < 20; i++) frame[i] = 8'h00;
    flen = 20;
    send_bytes(flen, 1'b0, 1'b1);
    check("sat_valid", {31'd0, res_valid}, 32'd1);
    check("sat_len", {28'd0, res_len}, 32'd15);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;

    load_031();
    send_bytes(flen, 1'b0, 1'b1);
    take_result("after_sat", 32'h2144DF1C, 32'd13, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/crc32_frame_checker.md
CRC32_FRAME_CHECKER -- requirements
Module: crc32_frame_checker

Interface
REQ-001 SHALL have parameter LEN_W, default 16, which is the width of the frame-length counter.
REQ-002 SHALL have parameter MIN_LEN, default 5, which is the minimum byte count for a frame to be checkable (4 FCS bytes plus 1 payload byte).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: a byte is offered.
REQ-006 SHALL have port in_ready, output, 1 bit: the checker accepts a byte.
REQ-007 SHALL have port in_data, input, 8 bits: the frame byte, with the FCS bytes transmitted LSB-first.
REQ-008 SHALL have port in_last, input, 1 bit: the offered byte is the final byte of the frame.
REQ-009 SHALL have port res_valid, output, 1 bit: a frame result is presented.
REQ-010 SHALL have port res_ready, input, 1 bit: the sink takes the result.
REQ-011 SHALL have port res_ok, output, 1 bit: the FCS residue matched and the length was at least MIN_LEN.
REQ-012 SHALL have port res_crc, output, 32 bits: the bitwise complement of the final CRC register.
REQ-013 SHALL have port res_len, output, LEN_W bits: accepted byte count, saturating.

Function
REQ-014 SHALL implement the reflected CRC-32 with polynomial 0xEDB88320, register init 0xFFFFFFFF, and 8 LSB-first shift steps per byte: reg ^= byte; then, 8 times, reg = (reg>>1) ^ (reg[0] ? POLY : 0).
REQ-015 SHALL transfer a byte when in_valid && in_ready are both high in the same cycle; nothing else SHALL advance the CRC register or the length counter.
REQ-016 SHALL use an FSM with exactly two states, ACCUM and RESULT; ACCUM SHALL be the reset state.
REQ-017 In ACCUM, in_ready SHALL be 1 and res_valid SHALL be 0; each transfer SHALL update the CRC register and increment the length counter by 1, saturating at 2^LEN_W-1.
REQ-018 On a transfer with in_last=1, the FSM SHALL enter RESULT on the next cycle (result latency of 1 clock after the last byte); res_crc, res_len and res_ok SHALL be registered from the post-byte values.
REQ-019 res_ok SHALL be 1 only if the post-last-byte register equals 0xDEBB20E3 AND the count (including the last byte) is at least MIN_LEN.
REQ-020 In RESULT, in_ready SHALL be 0 and res_valid SHALL be 1, and res_ok, res_crc and res_len SHALL be held stable until the cycle in which res_ready is 1.
REQ-021 When res_valid && res_ready, the next cycle SHALL be in ACCUM with the CRC register at 0xFFFFFFFF and the count at 0; there SHALL be no bubble beyond this one handshake cycle.
REQ-022 A length count that has saturated SHALL still be checked on residue and length (saturated value is at least MIN_LEN).
REQ-023 in_data and in_last SHALL be ignored whenever no transfer occurs.
REQ-024 in_ready SHALL NOT depend combinationally on res_ready; it SHALL be a function of the FSM state only.

Reset
REQ-025 While reset is high: state SHALL be ACCUM, the CRC register 0xFFFFFFFF, the count 0, res_valid 0, res_ok 0, res_crc 0, res_len 0, and in_ready 0.
REQ-026 in_ready SHALL rise in the first cycle after reset deasserts.
REQ-027 Reset asserted mid-frame or during RESULT SHALL discard the partial frame or the pending result, with no result emitted.

Structure
REQ-028 Package crc32_pkg SHALL hold: CRC32_POLY=32'hEDB88320, CRC32_INIT=32'hFFFFFFFF, CRC32_RESIDUE=32'hDEBB20E3, the FSM state enum, and the byte-step function, shared with the free-running randomizer.
REQ-029 The design SHALL contain one combinational sub-module, crc32_byte_step (inputs: 32-bit state and 8-bit data; output: 32-bit next state), and the checker SHALL instantiate it.

Verification
REQ-030 Bytes "123456789" (0x31..0x39, last on 0x39), res_ready=1 -> res_valid 1 cycle later; res_crc=0xCBF43926, res_len=9, res_ok=0.
REQ-031 "123456789" followed by 0x26 0x39 0xF4 0xCB (last on 0xCB) -> res_ok=1, res_len=13, res_crc=0x2144DF1C.
REQ-032 Single byte 0x61 with last -> res_crc=0xE8B7BE43, res_len=1, res_ok=0 (runt).
REQ-033 Frame of REQ-031 with res_ready held 0 for 3 cycles -> in_ready=0 and outputs stable throughout; a frame offered back-to-back is accepted in the cycle after the handshake and its result is correct.
REQ-034 Reset pulsed after 6 bytes of a frame, then the frame of REQ-030 is sent -> no result for the aborted frame; the next result equals REQ-030 exactly.
REQ-035 Random in_valid gaps applied to the REQ-031 frame -> result identical to REQ-031; CRC and count unchanged in idle cycles.
